// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline execution controller.
// The debug unit imports this package to decode the controller's
// busy/done status. It provides:
//   - NB_STATE and the fixed 2-bit state encodings
//   - state_e, an enum type built on those encodings
//   - REG_ZERO, the hard-wired zero register address
package pipeline_ctrl_pkg;

  localparam int NB_STATE = 2;

  localparam logic [NB_STATE-1:0] STATE_IDLE = 2'b00;
  localparam logic [NB_STATE-1:0] STATE_RUN  = 2'b01;
  localparam logic [NB_STATE-1:0] STATE_STEP = 2'b10;
  localparam logic [NB_STATE-1:0] STATE_DONE = 2'b11;

  typedef enum logic [NB_STATE-1:0] {
    IDLE = STATE_IDLE,
    RUN  = STATE_RUN,
    STEP = STATE_STEP,
    DONE = STATE_DONE
  } state_e;

  // Register 0 reads as zero and must never be written.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Saturating up-counter.
// Ports:
//   i_clock  - rising-edge clock
//   i_reset  - synchronous, active-high clear
//   i_enable - count this cycle
//   o_count  - current value; it holds at all-ones and never wraps
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_enable && (o_count != '1)) begin
      o_count <= o_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the five-stage pipeline.
// It decides when the pipeline advances: continuous run, single step or
// paused. Execution stops once a HALT instruction retires in writeback.
// The controller also gates the register-file write port and counts
// enabled cycles.
// Ports:
//   i_clock, i_reset          - clock; synchronous active-high reset
//   i_run, i_step             - debug commands (pulses)
//   i_pause                   - level; leaves continuous run
//   i_WB_halt                 - HALT is in writeback this cycle
//   i_WB_reg_write            - writeback register-write request
//   i_WB_selected_reg         - writeback destination register
//   o_pipeline_enable/o_busy  - pipeline advances this cycle
//   o_rf_write_enable         - gated register-file write enable
//   o_step_done               - the single-step cycle is executing
//   o_done                    - HALT has retired
//   o_cycle_count             - enabled cycles since reset (saturating)
module pipeline_exec_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NB_REG    = 5,
  parameter int NB_CYCLES = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic                 i_pause,
  input  logic                 i_WB_halt,
  input  logic                 i_WB_reg_write,
  input  logic [NB_REG-1:0]    i_WB_selected_reg,
  output logic                 o_pipeline_enable,
  output logic                 o_rf_write_enable,
  output logic                 o_step_done,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  state_e state;
  state_e state_next;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_run) begin
          state_next = RUN;
        end else if (i_step) begin
          state_next = STEP;
        end
      end
      RUN: begin
        // HALT takes priority so the program ends rather than merely pauses.
        if (i_WB_halt) begin
          state_next = DONE;
        end else if (i_pause) begin
          state_next = IDLE;
        end
      end
      STEP: begin
        state_next = i_WB_halt ? DONE : IDLE;
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign o_pipeline_enable = (state == RUN) || (state == STEP);
  assign o_busy            = o_pipeline_enable;
  assign o_step_done       = (state == STEP);
  assign o_done            = (state == DONE);

  assign o_rf_write_enable = i_WB_reg_write && o_pipeline_enable &&
                             (i_WB_selected_reg != NB_REG'(REG_ZERO));

  sat_counter #(
    .WIDTH(NB_CYCLES)
  ) u_cycle_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(o_pipeline_enable),
    .o_count (o_cycle_count)
  );

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
module tb_pipeline_exec_ctrl;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_run = 1'b0;
  logic        i_step = 1'b0;
  logic        i_pause = 1'b0;
  logic        i_WB_halt = 1'b0;
  logic        i_WB_reg_write = 1'b0;
  logic [4:0]  i_WB_selected_reg = '0;

  logic        pe, rf, sd, busy, done;
  logic [31:0] cnt;
  logic        pe4, rf4, sd4, busy4, done4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  pipeline_exec_ctrl #(
    .NB_REG(5),
    .NB_CYCLES(32)
  ) u_dut (
    .i_clock(clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_pause(i_pause), .i_WB_halt(i_WB_halt), .i_WB_reg_write(i_WB_reg_write),
    .i_WB_selected_reg(i_WB_selected_reg),
    .o_pipeline_enable(pe), .o_rf_write_enable(rf), .o_step_done(sd),
    .o_busy(busy), .o_done(done), .o_cycle_count(cnt)
  );

  pipeline_exec_ctrl #(
    .NB_REG(5),
    .NB_CYCLES(4)
  ) u_dut4 (
    .i_clock(clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_pause(i_pause), .i_WB_halt(i_WB_halt), .i_WB_reg_write(i_WB_reg_write),
    .i_WB_selected_reg(i_WB_selected_reg),
    .o_pipeline_enable(pe4), .o_rf_write_enable(rf4), .o_step_done(sd4),
    .o_busy(busy4), .o_done(done4), .o_cycle_count(cnt4)
  );

  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference model: mode flags and plain integer counters.
  bit     m_valid = 1'b0;
  bit     m_running = 1'b0;
  bit     m_stepping = 1'b0;
  bit     m_finished = 1'b0;
  longint m_count = 0;
  longint m_count4 = 0;

  // Values sampled during the most recent tick.
  bit          last_en, last_rf, last_done, last_sd;
  logic [31:0] last_cnt;
  logic [3:0]  last_cnt4;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model at the rising edge.
  task automatic tick(input bit rst, input bit run, input bit step, input bit pause,
                      input bit halt, input bit wr, input logic [4:0] sel);
    bit adv;
    bit exp_rf;
    @(negedge clk);
    i_reset = rst; i_run = run; i_step = step; i_pause = pause;
    i_WB_halt = halt; i_WB_reg_write = wr; i_WB_selected_reg = sel;
    #1;
    last_en = pe; last_rf = rf; last_done = done; last_sd = sd;
    last_cnt = cnt; last_cnt4 = cnt4;
    if (m_valid) begin
      adv = m_running || m_stepping;
      exp_rf = wr && adv && (sel != 5'd0);
      chk("enable", pe, adv);
      chk("busy", busy, adv);
      chk("step_done", sd, m_stepping);
      chk("done", done, m_finished);
      chk("rf_we", rf, exp_rf);
      chk("count", cnt, m_count);
      chk("enable4", pe4, adv);
      chk("rf_we4", rf4, exp_rf);
      chk("done4", {sd4, busy4, done4}, {m_stepping, adv, m_finished});
      chk("count4", cnt4, m_count4);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b1;
      m_running = 1'b0; m_stepping = 1'b0; m_finished = 1'b0;
      m_count = 0; m_count4 = 0;
    end else if (m_valid) begin
      if (m_running || m_stepping) begin
        if (m_count < 64'hFFFF_FFFF) m_count++;
        if (m_count4 < 15) m_count4++;
      end
      if (m_finished) begin
        // program over; only reset restarts it
      end else if (m_running) begin
        if (halt) begin m_running = 1'b0; m_finished = 1'b1; end
        else if (pause) m_running = 1'b0;
      end else if (m_stepping) begin
        m_stepping = 1'b0;
        if (halt) m_finished = 1'b1;
      end else begin
        if (run) m_running = 1'b1;
        else if (step) m_stepping = 1'b1;
      end
    end
  endtask

  task automatic idle_tick();
    tick(0, 0, 0, 0, 0, 0, 5'd0);
  endtask

  initial begin
    int unsigned ens;
    logic [5:0] pat;

    // Reset state
    tick(1, 0, 0, 0, 0, 0, 5'd0);
    idle_tick();
    chk("reset_cnt", last_cnt, 0);
    chk("reset_en", last_en, 0);

    // Run until HALT retires on the 10th enabled cycle
    tick(0, 1, 0, 0, 0, 0, 5'd0);
    ens = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(0, 0, 0, 0, (i == 10), 0, 5'd0);
      ens += last_en;
    end
    chk("halt_enables", ens, 10);
    ens = 0;
    for (int i = 0; i < 20; i++) begin
      tick(0, (i % 3 == 0), (i % 3 == 1), 0, 0, 0, 5'd0);
      ens += last_en;
    end
    chk("done_frozen", ens, 0);
    chk("done_flag", last_done, 1);
    chk("halt_count", last_cnt, 10);

    // Three separated single steps
    tick(1, 0, 0, 0, 0, 0, 5'd0);
    ens = 0;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 0, 0, 5'd0); ens += last_en;
      idle_tick();                   ens += last_sd;
      idle_tick();                   ens += last_en;
    end
    chk("step_cycles", ens, 3);
    chk("step_count", last_cnt, 3);

    // Held step: one step every two cycles
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      tick(0, 0, 1, 0, 0, 0, 5'd0);
      if (i > 0) pat = {pat[4:0], last_en};
    end
    chk("held_step_pattern", pat, 6'b101010);

    // run + step together: run wins
    tick(1, 0, 0, 0, 0, 0, 5'd0);
    tick(0, 1, 1, 0, 0, 0, 5'd0);
    ens = 0;
    for (int i = 0; i < 5; i++) begin idle_tick(); ens += last_en; end
    chk("run_over_step", ens, 5);

    // pause and halt together in RUN: halt wins
    tick(0, 0, 0, 1, 1, 0, 5'd0);
    idle_tick();
    chk("halt_over_pause", last_done, 1);

    // Register-file write gating
    tick(1, 0, 0, 0, 0, 0, 5'd0);
    tick(0, 0, 0, 0, 0, 1, 5'd0);
    chk("rf_idle_r0", last_rf, 0);
    tick(0, 0, 0, 0, 0, 1, 5'd5);
    chk("rf_idle_r5", last_rf, 0);
    tick(0, 1, 0, 0, 0, 0, 5'd0);
    tick(0, 0, 0, 0, 0, 1, 5'd5);
    chk("rf_run_r5", last_rf, 1);
    tick(0, 0, 0, 0, 0, 1, 5'd0);
    chk("rf_run_r0", last_rf, 0);

    // Saturation of the 4-bit counter
    tick(1, 0, 0, 0, 0, 0, 5'd0);
    tick(0, 1, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 20; i++) idle_tick();
    chk("sat4", last_cnt4, 15);
    chk("nosat32", last_cnt, 19);

    // Reset in mid-RUN
    tick(1, 0, 0, 0, 0, 0, 5'd0);
    idle_tick();
    chk("rst_run_en", {last_en, last_sd, last_done}, 3'b000);
    chk("rst_run_cnt", last_cnt, 0);
    tick(0, 1, 0, 0, 0, 0, 5'd0);
    idle_tick();
    idle_tick();
    tick(0, 0, 0, 0, 1, 0, 5'd0);
    idle_tick();
    chk("done_before_rst", last_done, 1);
    // Reset in DONE, then run again
    tick(1, 1, 0, 0, 0, 0, 5'd0);
    idle_tick();
    chk("rst_done_flags", {last_en, last_sd, last_done}, 3'b000);
    chk("rst_done_cnt", last_cnt, 0);
    tick(0, 1, 0, 0, 0, 0, 5'd0);
    idle_tick();
    chk("rerun_en", last_en, 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 14) == 0), 1'($urandom), 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
